// File: rtl/shift_sequencer.sv
// Shared iterative shifter for two requesters: round-robin grant, one bit per
// clock, result returned over a valid/ready channel tagged with the owner id.
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [SHW-1:0]   req0_shamt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [SHW-1:0]   req1_shamt,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             id_q, id_d;
  logic             resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;
  logic             resp_id_q, resp_id_d;

  logic             grant0, grant1;
  logic             accept, sel;
  logic [1:0]       acc_op;
  logic [WIDTH-1:0] acc_data;
  logic [SHW-1:0]   acc_shamt;
  logic [WIDTH-1:0] shifted;

  // On a tie, last_grant_q names the loser-to-be; it resets to 1 so port 0 wins first.
  assign grant0     = req0_valid & (~req1_valid | last_grant_q);
  assign grant1     = req1_valid & (~req0_valid | ~last_grant_q);
  assign req0_ready = (state_q == S_IDLE) & grant0;
  assign req1_ready = (state_q == S_IDLE) & grant1;

  assign accept    = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign sel       = req1_ready;
  assign acc_op    = sel ? req1_op    : req0_op;
  assign acc_data  = sel ? req1_data  : req0_data;
  assign acc_shamt = sel ? req1_shamt : req0_shamt;

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;

  always_comb begin
    shifted = work_q;
    case (op_q)
      OP_SLL:  shifted = {work_q[WIDTH-2:0], 1'b0};
      OP_SRL:  shifted = {1'b0, work_q[WIDTH-1:1]};
      OP_SRA:  shifted = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      OP_ROL:  shifted = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
      default: shifted = work_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    work_d       = work_q;
    cnt_d        = cnt_q;
    id_d         = id_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d         = acc_op;
          work_d       = acc_data;
          cnt_d        = acc_shamt;
          id_d         = sel;
          last_grant_d = sel;
          if (acc_shamt == '0) begin
            state_d      = S_DONE;
            resp_valid_d = 1'b1;
            resp_data_d  = acc_data;
            resp_id_d    = sel;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        work_d = shifted;
        cnt_d  = cnt_q - {{(SHW-1){1'b0}}, 1'b1};
        if (cnt_q == {{(SHW-1){1'b0}}, 1'b1}) begin
          state_d      = S_DONE;
          resp_valid_d = 1'b1;
          resp_data_d  = shifted;
          resp_id_d    = id_q;
        end
      end
      S_DONE: begin
        if (resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      op_q         <= 2'b00;
      work_q       <= '0;
      cnt_q        <= '0;
      id_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      work_q       <= work_d;
      cnt_q        <= cnt_d;
      id_q         <= id_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: directed vectors per port, grant-order
// expectations, and a decoupled response monitor checking data, id and latency.
module tb_shift_sequencer;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] data;
    logic [3:0]  sh;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic        id;
    logic [15:0] data;
    int          rise;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]  req0_op, req1_op;
  logic [15:0] req0_data, req1_data;
  logic [3:0]  req0_shamt, req1_shamt;
  logic        resp_valid, resp_ready, resp_id;
  logic [15:0] resp_data;

  vec_t q0[$];
  vec_t q1[$];
  sb_t  sb[$];
  logic exp_grant[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_acc1 = -1;

  shift_sequencer #(.WIDTH(16), .SHW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_data(req0_data), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_data(req1_data), .req1_shamt(req1_shamt),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [15:0] d,
                              input logic [3:0] sh, input logic [15:0] e);
    vec_t v;
    v.op = op; v.data = d; v.sh = sh; v.exp = e;
    return v;
  endfunction

  // Port drivers present the head of each queue just after the clock edge.
  initial forever begin
    @(posedge clk); #1;
    if (q0.size() > 0) begin
      req0_valid = 1'b1; req0_op = q0[0].op; req0_data = q0[0].data; req0_shamt = q0[0].sh;
    end else req0_valid = 1'b0;
    if (q1.size() > 0) begin
      req1_valid = 1'b1; req1_op = q1[0].op; req1_data = q1[0].data; req1_shamt = q1[0].sh;
    end else req1_valid = 1'b0;
  end

  task automatic record_accept(input logic id, input vec_t v);
    sb_t e;
    if (exp_grant.size() == 0) begin
      check("unexpected_grant", int'(id), 2);
    end else begin
      check("grant_order", int'(id), int'(exp_grant.pop_front()));
    end
    e.id = id; e.data = v.exp; e.rise = cyc + 1 + int'(v.sh);
    sb.push_back(e);
    $display("accept  port=%0d op=%0d data=0x%04h sh=%0d at cycle %0d", id, v.op, v.data, v.sh, cyc + 1);
    if (id) last_acc1 = cyc + 1;
  endtask

  // Accept watcher: a handshake seen at the negedge completes on the next posedge.
  initial forever begin
    @(negedge clk);
    if (rst_n && req0_valid && req0_ready && q0.size() > 0) record_accept(1'b0, q0.pop_front());
    if (rst_n && req1_valid && req1_ready && q1.size() > 0) record_accept(1'b1, q1.pop_front());
  end

  // Response monitor.
  initial begin : monitor
    logic prev_v;
    int   rise;
    sb_t  e;
    prev_v = 1'b0;
    rise   = 0;
    forever begin
      @(negedge clk);
      if (resp_valid && !prev_v) rise = cyc;
      prev_v = resp_valid;
      if (rst_n && resp_valid && resp_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", int'(resp_data), -1);
        end else begin
          e = sb.pop_front();
          $display("resp    id=%0d data=0x%04h rise=%0d", resp_id, resp_data, rise);
          check("resp_data", int'(resp_data), int'(e.data));
          check("resp_id", int'(resp_id), int'(e.id));
          check("resp_latency", rise, e.rise);
        end
      end
    end
  end

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0 && sb.size() == 0 &&
          exp_grant.size() == 0 && !resp_valid) done = 1'b1;
    end
    if (!done) check("timeout_idle", 0, 1);
  endtask

  initial begin
    int r;
    bit seen;
    rst_n = 1'b0; resp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = 2'b00; req1_op = 2'b00; req0_data = '0; req1_data = '0;
    req0_shamt = '0; req1_shamt = '0;
    repeat (3) @(negedge clk);
    check("rst_resp_valid", int'(resp_valid), 0);
    check("rst_resp_id", int'(resp_id), 0);
    check("rst_resp_data", int'(resp_data), 0);
    check("rst_req0_ready", int'(req0_ready), 0);
    check("rst_req1_ready", int'(req1_ready), 0);
    rst_n = 1'b1;

    // Tie straight after reset: grants 0,1,0,1.
    @(negedge clk);
    q0.push_back(mk(2'b00, 16'h00F0, 4'd4, 16'h0F00));
    q0.push_back(mk(2'b01, 16'h00F0, 4'd4, 16'h000F));
    q1.push_back(mk(2'b10, 16'hF000, 4'd2, 16'hFC00));
    q1.push_back(mk(2'b11, 16'h1234, 4'd4, 16'h2341));
    exp_grant.push_back(1'b0); exp_grant.push_back(1'b1);
    exp_grant.push_back(1'b0); exp_grant.push_back(1'b1);
    wait_idle();

    q0.push_back(mk(2'b00, 16'h0001, 4'd3, 16'h0008));
    exp_grant.push_back(1'b0);
    wait_idle();
    q1.push_back(mk(2'b01, 16'hABCD, 4'd0, 16'hABCD));
    exp_grant.push_back(1'b1);
    wait_idle();

    // Lone requester, back-to-back grants.
    q0.push_back(mk(2'b10, 16'h8000, 4'd4,  16'hF800));
    q0.push_back(mk(2'b01, 16'h8000, 4'd4,  16'h0800));
    q0.push_back(mk(2'b11, 16'h8001, 4'd1,  16'h0003));
    q0.push_back(mk(2'b00, 16'hFFFF, 4'd15, 16'h8000));
    q0.push_back(mk(2'b11, 16'h8421, 4'd15, 16'hC210));
    q0.push_back(mk(2'b10, 16'h4000, 4'd15, 16'h0000));
    q0.push_back(mk(2'b10, 16'h8000, 4'd15, 16'hFFFF));
    for (int i = 0; i < 7; i++) exp_grant.push_back(1'b0);
    wait_idle();

    // Backpressure in DONE.
    @(posedge clk); #1 resp_ready = 1'b0;
    @(negedge clk);
    q0.push_back(mk(2'b00, 16'h0003, 4'd2, 16'h000C));
    exp_grant.push_back(1'b0);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = resp_valid;
    end
    check("bp_valid_seen", int'(seen), 1);
    q0.push_back(mk(2'b01, 16'hFFFF, 4'd15, 16'h0001));
    q1.push_back(mk(2'b01, 16'h0C00, 4'd2,  16'h0300));
    exp_grant.push_back(1'b1); exp_grant.push_back(1'b0);
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", int'(resp_valid), 1);
      check("bp_data", int'(resp_data), 16'h000C);
      check("bp_id", int'(resp_id), 0);
      check("bp_req0_ready", int'(req0_ready), 0);
      check("bp_req1_ready", int'(req1_ready), 0);
    end
    @(posedge clk); #1 resp_ready = 1'b1;
    r = cyc;
    wait_idle();
    check("bp_resume_cycle", last_acc1, r + 2);

    // Reset in the middle of a long shift.
    @(negedge clk);
    q0.push_back(mk(2'b00, 16'h0001, 4'd10, 16'h0400));
    exp_grant.push_back(1'b0);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = (q0.size() == 0);
    end
    check("rst_op_accepted", int'(seen), 1);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_resp_valid", int'(resp_valid), 0);
    check("midrst_req0_ready", int'(req0_ready), 0);
    sb.delete();
    exp_grant.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (14) begin
      @(negedge clk);
      check("no_resp_after_rst", int'(resp_valid), 0);
    end
    q0.push_back(mk(2'b00, 16'h00FF, 4'd8, 16'hFF00));
    q1.push_back(mk(2'b10, 16'h8001, 4'd1, 16'hC000));
    exp_grant.push_back(1'b0); exp_grant.push_back(1'b1);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
